// File: rtl/demux_stream_dispatcher.sv
// demux_stream_dispatcher: steers beats from one valid/ready source to four
// sink lanes, round-robin in bursts or to an explicit destination, through a
// one-beat output buffer that also drives the demux select.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Ready never depends on valid. Once valid is raised it stays
// high, with data and select unchanged, until that transfer happens.
module demux_stream_dispatcher #(
   parameter int WIDTH = 8,
   parameter int BURST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_dest,
   input  logic             in_directed,
   input  logic [3:0]       lane_en,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       sel,
   output logic             drop_err,
   output logic             state_dbg
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [7:0] BURST_LEN = 8'(BURST);

   state_t     state_q;
   state_t     state_d;
   logic [1:0] ptr_q;
   logic [7:0] cnt_q;
   logic [1:0] rr_lane;
   logic       rr_found;
   logic [1:0] lane;
   logic       lane_ok;
   logic       accept;
   logic       drop;
   logic       load;
   logic       drain;
   logic [7:0] burst_n;

   // Find the first enabled lane at or after ptr, wrapping 3 -> 0.
   always_comb begin
      rr_lane  = ptr_q;
      rr_found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!rr_found && lane_en[ptr_q + 2'(i)]) begin
            rr_lane  = ptr_q + 2'(i);
            rr_found = 1'b1;
         end
      end
   end

   // A directed beat can always be taken (it is dropped if its lane is off);
   // a round-robin beat needs at least one enabled lane.
   assign lane     = in_directed ? in_dest : rr_lane;
   assign lane_ok  = in_directed | rr_found;
   assign in_ready = rst_n & lane_ok & ((state_q == EMPTY) | out_ready[sel]);
   assign accept   = in_valid & in_ready;
   assign drop     = accept & in_directed & ~lane_en[in_dest];
   assign load     = accept & ~drop;
   assign drain    = (state_q == FULL) & out_ready[sel];
   assign burst_n  = (rr_lane == ptr_q) ? (cnt_q + 8'd1) : 8'd1;
   assign state_dbg = state_q;

   // Buffer state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Next buffer state and lane valid decode.
   always_comb begin
      state_d   = state_q;
      out_valid = 4'b0000;
      case (state_q)
         EMPTY: begin
            if (load) state_d = FULL;
         end
         FULL: begin
            out_valid = 4'b0001 << sel;
            if (drain && !load) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Payload and select load together on every buffered accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data <= '0;
         sel      <= 2'd0;
      end else if (load) begin
         out_data <= in_data;
         sel      <= lane;
      end
   end

   // Round-robin pointer and burst count; directed beats leave them alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= 2'd0;
         cnt_q <= 8'd0;
      end else if (load && !in_directed) begin
         if (burst_n == BURST_LEN) begin
            ptr_q <= rr_lane + 2'd1;
            cnt_q <= 8'd0;
         end else begin
            ptr_q <= rr_lane;
            cnt_q <= burst_n;
         end
      end
   end

   // One-cycle pulse after a directed beat to a disabled lane is consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) drop_err <= 1'b0;
      else        drop_err <= drop;
   end

endmodule

// File: doc/demux_stream_dispatcher.md
# demux_stream_dispatcher

Sequential controller that sits in front of the 1-to-4 demultiplexer and turns it into a flow-controlled stream distributor. It accepts beats from a single valid/ready source and steers each beat to one of four sink lanes, either round-robin in configurable bursts or to an explicit destination. It generates the demux select and one-hot lane valids, and it buffers one beat so that sink back-pressure does not stall the selection logic.

## Interface

Parameters:
- WIDTH, 8: data beat width in bits.
- BURST, 1: number of consecutive beats sent to one lane in round-robin mode before rotating. Legal range 1..255.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low. Sampled on the rising edge of clk.
- in_valid, input, 1: source beat valid.
- in_ready, output, 1: dispatcher can accept a beat this cycle.
- in_data, input, WIDTH: source beat payload.
- in_dest, input, 2: destination lane, used only when in_directed=1.
- in_directed, input, 1: per-beat mode. 1 means send to in_dest; 0 means round-robin.
- lane_en, input, 4: lane enable mask. Disabled lanes never receive beats.
- out_valid, output, 4: one-hot lane valid, or 0 when the buffer is empty.
- out_ready, input, 4: per-lane sink ready.
- out_data, output, WIDTH: registered payload, shared by all lanes.
- sel, output, 2: registered demux select. Equals the index of the lane held in the buffer.
- drop_err, output, 1: one-cycle pulse when a directed beat targets a disabled lane.

## Operation

Output buffer state machine, states EMPTY and FULL:
- EMPTY: in_ready=1 unless the beat cannot be placed (see below). On an accept, go to FULL.
- FULL: the buffered lane is L=sel, and out_valid[L]=1. A drain happens when out_ready[L]=1.
  - Drain and no accept: go to EMPTY.
  - Drain and accept in the same cycle: stay FULL and load the new beat.
- In FULL, in_ready = out_ready[sel]. in_ready never depends on in_valid.
- Accept means in_valid && in_ready.

Lane choice:
- Directed mode: L = in_dest.
  - If lane_en[in_dest]=0, the beat is consumed but not buffered. drop_err pulses the next cycle and the state is unchanged.
  - Directed beats never touch ptr or cnt.
- Round-robin mode: L is the first enabled lane at or after ptr, searching cyclically (ptr, ptr+1, ... mod 4).
  - If lane_en=0, in_ready=0 for round-robin beats.
- Round-robin update on accept:
  - n = (L==ptr) ? cnt+1 : 1.
  - If n==BURST: ptr <= (L+1) mod 4, cnt <= 0.
  - Otherwise: ptr <= L, cnt <= n.
- ptr is 2 bits and wraps from 3 to 0. cnt is 8 bits.
- On a buffered accept, out_data, sel and out_valid load together from in_data and L.
- lane_en changes take effect at the next accept. A beat already buffered stays on its lane even if that lane is later disabled.

Reset (rst_n=0 at an edge):
- State EMPTY, out_valid=0, out_data=0, sel=0, ptr=0, cnt=0, drop_err=0.
- in_ready=0 while rst_n=0.
- Reset mid-operation discards the buffered beat with no drain.

## Timing

- Latency: a beat accepted at edge N is presented on out_valid/out_data/sel from edge N through the cycle its drain occurs.
- The minimum is one cycle from input to lane.
- Throughput is one beat per cycle when the targeted sinks hold ready high.
- out_valid is held stable, with data unchanged, until drained. No retraction.
- drop_err is high for exactly the one cycle after the offending accept.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, sel=0. Release -> first round-robin beat 0xA1 appears with out_valid=4'b0001.
- Round-robin, BURST=1, lane_en=4'hF, all ready, beats 0x10..0x17 -> out_valid sequence 1,2,4,8,1,2,4,8 on consecutive cycles with matching data, wrapping 3->0.
- BURST=2, lane_en=4'b1010, 6 beats -> lanes 1,1,3,3,1,1. Lanes 0 and 2 never valid.
- Back-pressure: out_ready[2]=0 for 4 cycles while lane 2 is buffered -> out_valid=4'b0100 with stable data, in_ready=0. On release, drain and accept in the same cycle with no bubble.
- Directed: in_dest=3 (enabled) -> out_valid=4'b1000 and ptr unchanged. in_dest=0 with lane_en[0]=0 -> no out_valid, drop_err pulses once.
- Mid-burst disable: BURST=3, after 1 beat on lane 0 clear lane_en[0] -> the next beat goes to lane 1 and a new burst starts (3 beats on lane 1).
